// File: rtl/serial_cmp_pkg.sv
// ---------------------------------------------------------------------------
// serial_cmp_pkg
//   Shared types and helpers for the multi-digit serial comparator.
//   - cmp_res_t  : encoded ordering of operand a relative to operand b
//   - ST_*_RST   : values the running compare state returns to at the start
//                  of every frame (after reset, clear or a completed frame)
//   - pack_flags : folds the three one-hot flags into a cmp_res_t; a flag
//                  combination that is not one-hot maps to the spare code
//                  2'b11 so that any checker sees it as a distinct value
// ---------------------------------------------------------------------------
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    CMP_LESS    = 2'd0,
    CMP_EQ      = 2'd1,
    CMP_GREATER = 2'd2
  } cmp_res_t;

  localparam logic ST_EQ_RST   = 1'b1;
  localparam logic ST_LESS_RST = 1'b0;

  function automatic cmp_res_t pack_flags(input logic lt, input logic eq,
                                          input logic gt);
    cmp_res_t r;
    case ({lt, eq, gt})
      3'b100:  r = CMP_LESS;
      3'b010:  r = CMP_EQ;
      3'b001:  r = CMP_GREATER;
      default: r = cmp_res_t'(2'b11);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/serial_cmp_digit.sv
// ---------------------------------------------------------------------------
// serial_cmp_digit
//   Purely combinational single-digit comparison.
//   Ports:
//     a, b    : DIGIT_W-bit digits of the two operands
//     is_msd  : the digit is the most significant one of the operand
//     eq_d    : a == b
//     lt_d    : a <  b (unsigned, or two's complement on the most
//               significant digit when SIGNED != 0)
// ---------------------------------------------------------------------------
module serial_cmp_digit #(
  parameter int DIGIT_W = 1,
  parameter int SIGNED  = 0
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               is_msd,
  output logic               eq_d,
  output logic               lt_d
);

  logic w_sign_diff;

  always_comb begin
    w_sign_diff = (a[DIGIT_W-1] != b[DIGIT_W-1]);
    eq_d        = (a == b);
    lt_d        = (a < b);
    // When the signs differ, the negative operand is the smaller one; with
    // equal signs the unsigned ordering already matches the signed one.
    if ((SIGNED != 0) && is_msd && w_sign_diff) begin
      lt_d = a[DIGIT_W-1];
    end
  end

endmodule

// File: rtl/serial_comparator_multi_digit.sv
// ---------------------------------------------------------------------------
// serial_comparator_multi_digit
//   Compares two N_DIGITS-digit numbers that arrive one DIGIT_W-bit digit per
//   accepted cycle, in MSB-first or LSB-first order, unsigned or two's
//   complement. Produces combinational running flags that already include
//   the digit on the inputs, and a registered per-frame result announced by
//   a one-cycle res_valid pulse.
//
//   Ports:
//     clk          : clock, all state updates on the rising edge
//     rst          : asynchronous, active-low reset
//     valid        : a/b carry a digit this cycle (0 = bubble, state held)
//     clear        : synchronous frame abort, wins over valid
//     a, b         : current digits of the two operands
//     a_less_b     : running ordering flags, exactly one high at a time
//     a_eq_b
//     a_greater_b
//     busy         : a frame is partially received (digit count != 0)
//     res_valid    : one-cycle pulse after the last digit of a frame
//     res_less     : final ordering of the last completed frame, held
//     res_eq
//     res_greater
// ---------------------------------------------------------------------------
module serial_comparator_multi_digit
  import serial_cmp_pkg::*;
#(
  parameter int DIGIT_W   = 1,
  parameter int N_DIGITS  = 16,
  parameter int MSB_FIRST = 1,
  parameter int SIGNED    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic               clear,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               a_less_b,
  output logic               a_eq_b,
  output logic               a_greater_b,
  output logic               busy,
  output logic               res_valid,
  output logic               res_less,
  output logic               res_eq,
  output logic               res_greater
);

  localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] MSD_POS  = (MSB_FIRST != 0) ? '0 : LAST_POS;

  logic [CNT_W-1:0] r_cnt;
  logic             r_st_eq;
  logic             r_st_less;
  logic             r_res_valid;
  logic             r_res_less;
  logic             r_res_eq;
  logic             r_res_greater;

  logic w_is_msd;
  logic w_eq_d;
  logic w_lt_d;
  logic w_n_eq;
  logic w_n_less;
  logic w_n_greater;
  logic w_last;

  assign w_is_msd = (r_cnt == MSD_POS);
  assign w_last   = (r_cnt == LAST_POS);

  serial_cmp_digit #(
    .DIGIT_W (DIGIT_W),
    .SIGNED  (SIGNED)
  ) u_digit (
    .a      (a),
    .b      (b),
    .is_msd (w_is_msd),
    .eq_d   (w_eq_d),
    .lt_d   (w_lt_d)
  );

  // Next compare state if the current digit were accepted. MSB-first: an
  // earlier decision is final, only a still-equal prefix looks at the new
  // digit. LSB-first: the new digit outranks everything seen so far, and
  // only an equal digit lets the older decision through.
  always_comb begin
    w_n_eq = r_st_eq & w_eq_d;
    if (MSB_FIRST != 0) begin
      w_n_less = r_st_less | (r_st_eq & w_lt_d);
    end else begin
      w_n_less = w_lt_d | (w_eq_d & r_st_less);
    end
    w_n_greater = ~w_n_eq & ~w_n_less;
  end

  always_comb begin
    if (valid) begin
      a_less_b    = w_n_less;
      a_eq_b      = w_n_eq;
      a_greater_b = w_n_greater;
    end else begin
      a_less_b    = r_st_less;
      a_eq_b      = r_st_eq;
      a_greater_b = ~r_st_eq & ~r_st_less;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt         <= '0;
      r_st_eq       <= ST_EQ_RST;
      r_st_less     <= ST_LESS_RST;
      r_res_valid   <= 1'b0;
      r_res_less    <= 1'b0;
      r_res_eq      <= 1'b1;
      r_res_greater <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (clear) begin
        r_cnt     <= '0;
        r_st_eq   <= ST_EQ_RST;
        r_st_less <= ST_LESS_RST;
      end else if (valid) begin
        if (w_last) begin
          // Frame complete: publish the result and rearm for a following
          // frame that may start on the very next cycle.
          r_cnt         <= '0;
          r_st_eq       <= ST_EQ_RST;
          r_st_less     <= ST_LESS_RST;
          r_res_valid   <= 1'b1;
          r_res_less    <= w_n_less;
          r_res_eq      <= w_n_eq;
          r_res_greater <= w_n_greater;
        end else begin
          r_cnt     <= r_cnt + 1'b1;
          r_st_eq   <= w_n_eq;
          r_st_less <= w_n_less;
        end
      end
    end
  end

  assign busy        = (r_cnt != '0);
  assign res_valid   = r_res_valid;
  assign res_less    = r_res_less;
  assign res_eq      = r_res_eq;
  assign res_greater = r_res_greater;

endmodule

// File: tb/tb_serial_comparator_multi_digit.sv
module tb_serial_comparator_multi_digit;
  import serial_cmp_pkg::*;

  localparam int NI = 6;
  // Instance configurations; P_G selects which input group drives each.
  localparam int P_W[NI]   = '{1, 1, 4, 4, 4, 4};
  localparam int P_N[NI]   = '{16, 16, 4, 4, 2, 2};
  localparam int P_MSB[NI] = '{1, 0, 1, 0, 1, 1};
  localparam int P_SG[NI]  = '{0, 0, 0, 1, 1, 0};
  localparam int P_G[NI]   = '{0, 0, 1, 1, 2, 2};

  logic clk = 1'b0;
  logic rst;
  logic [2:0] vin, cin;
  logic [0:0] a0, b0;
  logic [3:0] a1, b1, a2, b2;
  logic [NI-1:0] lt, eq, gt, bsy, rv, rl, re, rg;

  always #5 clk = ~clk;

  serial_comparator_multi_digit #(.DIGIT_W(1), .N_DIGITS(16), .MSB_FIRST(1), .SIGNED(0)) u0 (
    .clk(clk), .rst(rst), .valid(vin[0]), .clear(cin[0]), .a(a0), .b(b0),
    .a_less_b(lt[0]), .a_eq_b(eq[0]), .a_greater_b(gt[0]), .busy(bsy[0]),
    .res_valid(rv[0]), .res_less(rl[0]), .res_eq(re[0]), .res_greater(rg[0]));
  serial_comparator_multi_digit #(.DIGIT_W(1), .N_DIGITS(16), .MSB_FIRST(0), .SIGNED(0)) u1 (
    .clk(clk), .rst(rst), .valid(vin[0]), .clear(cin[0]), .a(a0), .b(b0),
    .a_less_b(lt[1]), .a_eq_b(eq[1]), .a_greater_b(gt[1]), .busy(bsy[1]),
    .res_valid(rv[1]), .res_less(rl[1]), .res_eq(re[1]), .res_greater(rg[1]));
  serial_comparator_multi_digit #(.DIGIT_W(4), .N_DIGITS(4), .MSB_FIRST(1), .SIGNED(0)) u2 (
    .clk(clk), .rst(rst), .valid(vin[1]), .clear(cin[1]), .a(a1), .b(b1),
    .a_less_b(lt[2]), .a_eq_b(eq[2]), .a_greater_b(gt[2]), .busy(bsy[2]),
    .res_valid(rv[2]), .res_less(rl[2]), .res_eq(re[2]), .res_greater(rg[2]));
  serial_comparator_multi_digit #(.DIGIT_W(4), .N_DIGITS(4), .MSB_FIRST(0), .SIGNED(1)) u3 (
    .clk(clk), .rst(rst), .valid(vin[1]), .clear(cin[1]), .a(a1), .b(b1),
    .a_less_b(lt[3]), .a_eq_b(eq[3]), .a_greater_b(gt[3]), .busy(bsy[3]),
    .res_valid(rv[3]), .res_less(rl[3]), .res_eq(re[3]), .res_greater(rg[3]));
  serial_comparator_multi_digit #(.DIGIT_W(4), .N_DIGITS(2), .MSB_FIRST(1), .SIGNED(1)) u4 (
    .clk(clk), .rst(rst), .valid(vin[2]), .clear(cin[2]), .a(a2), .b(b2),
    .a_less_b(lt[4]), .a_eq_b(eq[4]), .a_greater_b(gt[4]), .busy(bsy[4]),
    .res_valid(rv[4]), .res_less(rl[4]), .res_eq(re[4]), .res_greater(rg[4]));
  serial_comparator_multi_digit #(.DIGIT_W(4), .N_DIGITS(2), .MSB_FIRST(1), .SIGNED(0)) u5 (
    .clk(clk), .rst(rst), .valid(vin[2]), .clear(cin[2]), .a(a2), .b(b2),
    .a_less_b(lt[5]), .a_eq_b(eq[5]), .a_greater_b(gt[5]), .busy(bsy[5]),
    .res_valid(rv[5]), .res_less(rl[5]), .res_eq(re[5]), .res_greater(rg[5]));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the digits of the current frame in arrival order, the
  // last published result and whether a result is being announced.
  int unsigned ma[NI][16];
  int unsigned mb[NI][16];
  int          mcnt[NI];
  cmp_res_t    mres[NI];
  bit          mrv[NI];

  // Stimulus for the next step, per input group.
  bit [2:0]    s_v, s_c;
  int unsigned s_a[3], s_b[3];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Orders the numbers formed by the first k digits of the frame. The
  // partial numbers are built with the digit order of the instance; they are
  // two's complement only when their top digit is the operand's sign digit.
  function automatic cmp_res_t ref_cmp(input int inst, input int k);
    longint av = 0;
    longint bv = 0;
    int w = P_W[inst];
    int bits = k * w;
    for (int i = 0; i < k; i++) begin
      int pos;
      pos = (P_MSB[inst] != 0) ? (k - 1 - i) : i;
      av = av | (longint'(ma[inst][i]) << (pos * w));
      bv = bv | (longint'(mb[inst][i]) << (pos * w));
    end
    if (bits > 0 && P_SG[inst] != 0 && (P_MSB[inst] != 0 || k == P_N[inst])) begin
      if (((av >> (bits - 1)) & 1) != 0) av = av - (longint'(1) << bits);
      if (((bv >> (bits - 1)) & 1) != 0) bv = bv - (longint'(1) << bits);
    end
    if (av < bv) return CMP_LESS;
    if (av == bv) return CMP_EQ;
    return CMP_GREATER;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mcnt[i] = 0;
      mres[i] = CMP_EQ;
      mrv[i]  = 1'b0;
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs on the falling
  // edge, check running flags, then advance the model past the rising edge.
  task automatic step();
    cmp_res_t exp_run[NI];
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("res_valid[%0d]", i), int'(rv[i]), int'(mrv[i]));
      check($sformatf("res[%0d]", i), int'(pack_flags(rl[i], re[i], rg[i])), int'(mres[i]));
      check($sformatf("busy[%0d]", i), int'(bsy[i]), int'(mcnt[i] != 0));
    end
    vin = s_v;
    cin = s_c;
    a0 = 1'(s_a[0]); b0 = 1'(s_b[0]);
    a1 = 4'(s_a[1]); b1 = 4'(s_b[1]);
    a2 = 4'(s_a[2]); b2 = 4'(s_b[2]);
    #2;
    for (int i = 0; i < NI; i++) begin
      int g;
      g = P_G[i];
      if (s_v[g]) begin
        ma[i][mcnt[i]] = s_a[g] & ((1 << P_W[i]) - 1);
        mb[i][mcnt[i]] = s_b[g] & ((1 << P_W[i]) - 1);
        exp_run[i] = ref_cmp(i, mcnt[i] + 1);
      end else begin
        exp_run[i] = ref_cmp(i, mcnt[i]);
      end
      check($sformatf("running[%0d]", i), int'(pack_flags(lt[i], eq[i], gt[i])), int'(exp_run[i]));
      mrv[i] = 1'b0;
      if (s_c[g]) begin
        mcnt[i] = 0;
      end else if (s_v[g]) begin
        if (mcnt[i] == P_N[i] - 1) begin
          mres[i] = exp_run[i];
          mrv[i]  = 1'b1;
          mcnt[i] = 0;
        end else begin
          mcnt[i]++;
        end
      end
    end
  endtask

  task automatic idle();
    s_v = '0;
    s_c = '0;
    step();
  endtask

  task automatic feed1(input int unsigned da, input int unsigned db);
    s_v = 3'b010; s_c = '0; s_a[1] = da; s_b[1] = db;
    step();
  endtask

  typedef struct {
    bit       a;
    bit       b;
    cmp_res_t e_msb;
    cmp_res_t e_lsb;
  } vec1_t;

  function automatic cmp_res_t code_of(input byte ch);
    if (ch == "E") return CMP_EQ;
    if (ch == "G") return CMP_GREATER;
    return CMP_LESS;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec1_t       tv[16];
    logic [15:0] pa, pb;
    string       em, el;
    int          pulses, first_at, second_at;
    int unsigned fa[4], fb[4];

    rst = 1'b0; vin = '0; cin = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    s_v = '0; s_c = '0;
    for (int g = 0; g < 3; g++) begin s_a[g] = 0; s_b[g] = 0; end
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_res_valid[%0d]", i), int'(rv[i]), 0);
      check($sformatf("rst_res[%0d]", i), int'(pack_flags(rl[i], re[i], rg[i])), int'(CMP_EQ));
      check($sformatf("rst_run[%0d]", i), int'(pack_flags(lt[i], eq[i], gt[i])), int'(CMP_EQ));
      check($sformatf("rst_busy[%0d]", i), int'(bsy[i]), 0);
    end
    rst = 1'b1;

    // 1-bit, 16-digit streams, MSB-first and LSB-first interpretation.
    pa = 16'b0110_0100_1000_0010;
    pb = 16'b0110_0010_0110_0010;
    em = "EEEEEGGGGGGGGGGG";
    el = "EEEEEGLLGLLLLLLL";
    for (int i = 0; i < 16; i++) begin
      tv[i].a     = pa[15-i];
      tv[i].b     = pb[15-i];
      tv[i].e_msb = code_of(em[i]);
      tv[i].e_lsb = code_of(el[i]);
    end
    for (int i = 0; i < 16; i++) begin
      s_v = 3'b001; s_c = '0; s_a[0] = tv[i].a; s_b[0] = tv[i].b;
      step();
      check($sformatf("plan_msb_d%0d", i), int'(pack_flags(lt[0], eq[0], gt[0])), int'(tv[i].e_msb));
      check($sformatf("plan_lsb_d%0d", i), int'(pack_flags(lt[1], eq[1], gt[1])), int'(tv[i].e_lsb));
    end
    idle();
    check("plan_msb_rv", int'(rv[0]), 1);
    check("plan_msb_res", int'(pack_flags(rl[0], re[0], rg[0])), int'(CMP_GREATER));
    check("plan_lsb_res", int'(pack_flags(rl[1], re[1], rg[1])), int'(CMP_LESS));
    idle();
    check("plan_rv_pulse", int'(rv[0]), 0);

    // 4-bit, 4 digits: 0x1234 vs 0x1243 with a bubble after digit 1.
    fa = '{1, 2, 3, 4}; fb = '{1, 2, 4, 3};
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      feed1(fa[i], fb[i]);
      pulses += int'(rv[2]);
      if (i == 1) begin
        idle();
        pulses += int'(rv[2]);
        check("bubble_busy", int'(bsy[2]), 1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      pulses += int'(rv[2]);
    end
    check("gap_pulses", pulses, 1);
    check("gap_res", int'(pack_flags(rl[2], re[2], rg[2])), int'(CMP_LESS));
    check("gap_busy_end", int'(bsy[2]), 0);

    // 2-digit signed vs unsigned: 0x80 vs 0x7F, then 0x55 vs 0x55.
    s_c = '0; s_v = 3'b100; s_a[2] = 8; s_b[2] = 7;   step();
    s_a[2] = 0; s_b[2] = 15;                          step();
    idle();
    check("sgn_res", int'(pack_flags(rl[4], re[4], rg[4])), int'(CMP_LESS));
    check("uns_res", int'(pack_flags(rl[5], re[5], rg[5])), int'(CMP_GREATER));
    s_v = 3'b100; s_a[2] = 5; s_b[2] = 5; step();
    step();
    idle();
    check("eq_res_s", int'(pack_flags(rl[4], re[4], rg[4])), int'(CMP_EQ));
    check("eq_res_u", int'(pack_flags(rl[5], re[5], rg[5])), int'(CMP_EQ));

    // Abort with clear on digit 2, then a full frame 0x0001 vs 0x0000.
    feed1(0, 0);
    feed1(0, 0);
    s_v = 3'b010; s_c = 3'b010; s_a[1] = 9; s_b[1] = 1; step();
    idle();
    check("clear_no_rv", int'(rv[2]), 0);
    check("clear_busy", int'(bsy[2]), 0);
    fa = '{0, 0, 0, 1}; fb = '{0, 0, 0, 0};
    for (int i = 0; i < 4; i++) feed1(fa[i], fb[i]);
    idle();
    check("after_clear_rv", int'(rv[2]), 1);
    check("after_clear_res", int'(pack_flags(rl[2], re[2], rg[2])), int'(CMP_GREATER));

    // Back-to-back frames: pulses exactly 4 cycles apart.
    first_at = -1; second_at = -1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) feed1($urandom_range(15), $urandom_range(15));
      else idle();
      if (rv[2]) begin
        if (first_at < 0) first_at = i;
        else second_at = i;
      end
    end
    check("b2b_spacing", second_at - first_at, 4);

    // Asynchronous reset in the middle of a frame.
    feed1(3, 2);
    feed1(7, 7);
    #1;
    s_v = '0; s_c = '0; vin = '0; cin = '0;
    rst = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("arst_rv[%0d]", i), int'(rv[i]), 0);
      check($sformatf("arst_res[%0d]", i), int'(pack_flags(rl[i], re[i], rg[i])), int'(CMP_EQ));
      check($sformatf("arst_run[%0d]", i), int'(pack_flags(lt[i], eq[i], gt[i])), int'(CMP_EQ));
      check($sformatf("arst_busy[%0d]", i), int'(bsy[i]), 0);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    fa = '{0, 0, 15, 15}; fb = '{0, 15, 0, 0};
    for (int i = 0; i < 4; i++) feed1(fa[i], fb[i]);
    idle();
    check("post_rst_rv", int'(rv[2]), 1);
    check("post_rst_res", int'(pack_flags(rl[2], re[2], rg[2])), int'(CMP_LESS));

    // Random traffic on all groups: bubbles, aborts, back-to-back frames.
    for (int n = 0; n < 400; n++) begin
      for (int g = 0; g < 3; g++) begin
        s_v[g] = ($urandom_range(9) < 7);
        s_c[g] = ($urandom_range(39) == 0);
        s_a[g] = $urandom_range(15);
        s_b[g] = ($urandom_range(3) == 0) ? s_a[g] : $urandom_range(15);
      end
      step();
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
